// File: rtl/cplx_pkg.sv
// Shared definitions for the packed complex datapath: default widths,
// the packed complex word type, pack/unpack helpers and saturation limits.
package cplx_pkg;

    localparam int CW_DEFAULT   = 8;
    localparam int FRAC_DEFAULT = 2;

    // Real component occupies the upper half of the packed word.
    typedef struct packed {
        logic [CW_DEFAULT-1:0] re;
        logic [CW_DEFAULT-1:0] im;
    } cplx_t;

    localparam logic [CW_DEFAULT-1:0] SAT_MAX = {1'b0, {(CW_DEFAULT-1){1'b1}}};
    localparam logic [CW_DEFAULT-1:0] SAT_MIN = {1'b1, {(CW_DEFAULT-1){1'b0}}};

    function automatic cplx_t cplx_pack(input logic [CW_DEFAULT-1:0] re,
                                        input logic [CW_DEFAULT-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

    function automatic logic [CW_DEFAULT-1:0] cplx_re(input cplx_t c);
        return c.re;
    endfunction

    function automatic logic [CW_DEFAULT-1:0] cplx_im(input cplx_t c);
        return c.im;
    endfunction

endpackage

// File: rtl/cplx_comp_add.sv
// One signed component of the complex adder/subtractor: CW+1-bit add or
// subtract, overflow detect, and optional clamp to the CW-bit signed range.
module cplx_comp_add
    import cplx_pkg::*;
#(
    parameter int CW       = CW_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          sub,
    output logic [CW-1:0] y,
    output logic          ovf
);

    localparam logic [CW-1:0] LIM_MAX = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] LIM_MIN = {1'b1, {(CW-1){1'b0}}};

    logic [CW:0] w_a;
    logic [CW:0] w_b;
    logic [CW:0] w_r;

    assign w_a = {a[CW-1], a};
    assign w_b = {b[CW-1], b};
    assign w_r = sub ? (w_a - w_b) : (w_a + w_b);

    // Result fits in CW bits only when the two top bits agree; w_r[CW] is the true sign.
    assign ovf = w_r[CW] ^ w_r[CW-1];

    always_comb begin
        y = w_r[CW-1:0];
        if (SATURATE && ovf) begin
            y = w_r[CW] ? LIM_MIN : LIM_MAX;
        end
    end

endmodule

// File: rtl/complex_adder.sv
// Registered complex adder/subtractor for the FFT butterfly: two independent
// component units feeding one output register stage (latency 1).
module complex_adder
    import cplx_pkg::*;
#(
    parameter int CW       = CW_DEFAULT,
    parameter int FRAC     = FRAC_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic          i_sub,
    input  logic [2*CW-1:0] i_A,
    input  logic [2*CW-1:0] i_B,
    output logic          o_valid,
    output logic [2*CW-1:0] o_sum,
    output logic [1:0]    o_ovf
);

    // Handshake: valid-only, no ready. Operands are taken on every edge where
    // i_valid is high; o_valid follows one cycle later and the consumer must
    // take o_sum/o_ovf in that cycle. With i_valid low the outputs hold.
    if (FRAC < 0 || FRAC >= CW) begin : g_frac_check
        $error("complex_adder: FRAC must lie in [0, CW-1]");
    end

    logic [CW-1:0] w_re_y;
    logic [CW-1:0] w_im_y;
    logic          w_re_ovf;
    logic          w_im_ovf;

    cplx_comp_add #(.CW(CW), .SATURATE(SATURATE)) u_re (
        .a   (i_A[2*CW-1:CW]),
        .b   (i_B[2*CW-1:CW]),
        .sub (i_sub),
        .y   (w_re_y),
        .ovf (w_re_ovf)
    );

    cplx_comp_add #(.CW(CW), .SATURATE(SATURATE)) u_im (
        .a   (i_A[CW-1:0]),
        .b   (i_B[CW-1:0]),
        .sub (i_sub),
        .y   (w_im_y),
        .ovf (w_im_ovf)
    );

    logic            r_valid;
    logic [2*CW-1:0] r_sum;
    logic [1:0]      r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 2'b00;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sum <= {w_re_y, w_im_y};
                r_ovf <= {w_re_ovf, w_im_ovf};
            end
        end
    end

    assign o_valid = r_valid;
    assign o_sum   = r_sum;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_complex_adder.sv
// Directed bench for complex_adder: a wrapping and a saturating instance
// share one stimulus stream and are checked against hand-computed results.
module tb_complex_adder;
    import cplx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sub;
    logic [15:0] in_a;
    logic [15:0] in_b;

    logic        w_valid, s_valid;
    logic [15:0] w_sum, s_sum;
    logic [1:0]  w_ovf, s_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    complex_adder #(.CW(8), .FRAC(2), .SATURATE(1'b0)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .i_sub(in_sub),
        .i_A(in_a), .i_B(in_b),
        .o_valid(w_valid), .o_sum(w_sum), .o_ovf(w_ovf)
    );

    complex_adder #(.CW(8), .FRAC(2), .SATURATE(1'b1)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .i_sub(in_sub),
        .i_A(in_a), .i_B(in_b),
        .o_valid(s_valid), .o_sum(s_sum), .o_ovf(s_ovf)
    );

    // Present one operand pair at the falling edge, return just after the capturing edge.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sub);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (w_valid !== 1'b0 || w_sum !== 16'h0000 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL reset_wrap: got v=%b sum=%h ovf=%b, expected v=0 sum=0000 ovf=00", w_valid, w_sum, w_ovf);
        end
        checks++;
        if (s_valid !== 1'b0 || s_sum !== 16'h0000 || s_ovf !== 2'b00) begin
            errors++;
            $display("FAIL reset_sat: got v=%b sum=%h ovf=%b, expected v=0 sum=0000 ovf=00", s_valid, s_sum, s_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(16'h0421, 16'h0224, 1'b0);
        checks++;
        if (w_valid !== 1'b1 || w_sum !== 16'h0645 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL add_plain: got v=%b sum=%h ovf=%b, expected v=1 sum=0645 ovf=00", w_valid, w_sum, w_ovf);
        end
        checks++;
        if (s_sum !== 16'h0645 || s_ovf !== 2'b00) begin
            errors++;
            $display("FAIL add_plain_sat: got sum=%h ovf=%b, expected sum=0645 ovf=00", s_sum, s_ovf);
        end
        drive(cplx_pack(8'h0A, 8'hEF), cplx_pack(8'h0D, 8'h16), 1'b0);
        checks++;
        if (w_sum !== 16'h1705 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL add_fixed_point: got sum=%h ovf=%b, expected sum=1705 ovf=00", w_sum, w_ovf);
        end
        checks++;
        if (s_sum !== 16'h1705 || s_ovf !== 2'b00) begin
            errors++;
            $display("FAIL add_fixed_point_sat: got sum=%h ovf=%b, expected sum=1705 ovf=00", s_sum, s_ovf);
        end
    endtask

    task automatic test_overflow();
        drive(16'h7F80, 16'h01FF, 1'b0);
        checks++;
        if (w_sum !== 16'h807F || w_ovf !== 2'b11) begin
            errors++;
            $display("FAIL ovf_wrap: got sum=%h ovf=%b, expected sum=807F ovf=11", w_sum, w_ovf);
        end
        checks++;
        if (s_sum !== 16'h7F80 || s_ovf !== 2'b11) begin
            errors++;
            $display("FAIL ovf_sat: got sum=%h ovf=%b, expected sum=7F80 ovf=11", s_sum, s_ovf);
        end
    endtask

    task automatic test_subtract();
        drive(16'h0500, 16'h0380, 1'b1);
        checks++;
        if (w_sum !== 16'h0280 || w_ovf !== 2'b01) begin
            errors++;
            $display("FAIL sub_minneg_wrap: got sum=%h ovf=%b, expected sum=0280 ovf=01", w_sum, w_ovf);
        end
        checks++;
        if (s_sum !== 16'h027F || s_ovf !== 2'b01) begin
            errors++;
            $display("FAIL sub_minneg_sat: got sum=%h ovf=%b, expected sum=027F ovf=01", s_sum, s_ovf);
        end
        drive(16'h0010, 16'h0020, 1'b1);
        checks++;
        if (w_sum !== 16'h00F0 || w_ovf !== 2'b00 || s_sum !== 16'h00F0 || s_ovf !== 2'b00) begin
            errors++;
            $display("FAIL sub_negative: got wrap=%h/%b sat=%h/%b, expected 00F0/00 for both", w_sum, w_ovf, s_sum, s_ovf);
        end
        drive(16'h8000, 16'h0100, 1'b1);
        checks++;
        if (w_sum !== 16'h7F00 || w_ovf !== 2'b10) begin
            errors++;
            $display("FAIL sub_negovf_wrap: got sum=%h ovf=%b, expected sum=7F00 ovf=10", w_sum, w_ovf);
        end
        checks++;
        if (s_sum !== 16'h8000 || s_ovf !== 2'b10) begin
            errors++;
            $display("FAIL sub_negovf_sat: got sum=%h ovf=%b, expected sum=8000 ovf=10", s_sum, s_ovf);
        end
    endtask

    task automatic test_hold();
        drive(16'h0421, 16'h0224, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 16'h7F7F;
        in_b     = 16'h7F7F;
        in_sub   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (w_valid !== 1'b0 || w_sum !== 16'h0645 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL hold_idle: got v=%b sum=%h ovf=%b, expected v=0 sum=0645 ovf=00", w_valid, w_sum, w_ovf);
        end
        checks++;
        if (s_valid !== 1'b0 || s_sum !== 16'h0645) begin
            errors++;
            $display("FAIL hold_idle_sat: got v=%b sum=%h, expected v=0 sum=0645", s_valid, s_sum);
        end
    endtask

    task automatic test_back_to_back();
        drive(16'hFFFE, 16'hFE05, 1'b0);
        checks++;
        if (w_valid !== 1'b1 || w_sum !== 16'hFD03 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL b2b_negatives: got v=%b sum=%h ovf=%b, expected v=1 sum=FD03 ovf=00", w_valid, w_sum, w_ovf);
        end
        drive(16'd67, 16'd420, 1'b0);
        checks++;
        if (w_valid !== 1'b1 || w_sum !== 16'h01E7 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL b2b_isolation: got v=%b sum=%h ovf=%b, expected v=1 sum=01E7 ovf=00", w_valid, w_sum, w_ovf);
        end
        drive(16'h7F80, 16'h01FF, 1'b0);
        checks++;
        if (w_sum !== 16'h807F || s_sum !== 16'h7F80 || w_ovf !== 2'b11 || s_ovf !== 2'b11) begin
            errors++;
            $display("FAIL b2b_overflow: got wrap=%h/%b sat=%h/%b, expected 807F/11 and 7F80/11", w_sum, w_ovf, s_sum, s_ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        drive(16'h0500, 16'h0380, 1'b1);
        checks++;
        if (w_valid !== 1'b1 || w_sum !== 16'h0280) begin
            errors++;
            $display("FAIL midrst_before: got v=%b sum=%h, expected v=1 sum=0280", w_valid, w_sum);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_valid !== 1'b0 || w_sum !== 16'h0000 || w_ovf !== 2'b00 ||
            s_valid !== 1'b0 || s_sum !== 16'h0000 || s_ovf !== 2'b00) begin
            errors++;
            $display("FAIL midrst_async: got wrap v=%b %h/%b sat v=%b %h/%b, expected all zero",
                     w_valid, w_sum, w_ovf, s_valid, s_sum, s_ovf);
        end
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'h7F80; in_b = 16'h01FF; in_sub = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (w_valid !== 1'b0 || w_sum !== 16'h0000 || s_sum !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_held: got v=%b wrap=%h sat=%h, expected v=0 and zero sums", w_valid, w_sum, s_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_a = 16'h0421; in_b = 16'h0224;
        @(posedge clk);
        #1;
        checks++;
        if (w_valid !== 1'b1 || w_sum !== 16'h0645 || w_ovf !== 2'b00) begin
            errors++;
            $display("FAIL midrst_first_after: got v=%b sum=%h ovf=%b, expected v=1 sum=0645 ovf=00", w_valid, w_sum, w_ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_subtract();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
